psum_out_collector: RTL

Reader for the systolic array's 128-bit multiplexed partial-sum output. It drives `output_group_sel`, freezes the array for one cycle, and captures columns 0-3 and then columns 4-7 into one 256-bit row result. It presents the result downstream on a valid/ready interface and counts results per tile. It sits between the array's `psum_out_bus` and the output buffer or writeback path. The array controller gates the array's `enable_cycle` with `!array_hold`.

---
 rtl/psum_collect_pkg.sv | 31 +++
 rtl/psum_relu_lane.sv | 21 ++
 rtl/psum_out_collector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/psum_collect_pkg.sv
// ----------------------------------------------------------------------------
// psum_collect_pkg
// Shared definitions for the systolic-array partial-sum output collector.
//   COLS            : array columns (fixed at 8 for the two-group split)
//   SUM_WIDTH       : bits per column partial sum
//   BUS_WIDTH       : width of the multiplexed array output bus (half a row)
//   ROW_WIDTH       : width of one assembled row result
//   LANES_PER_GROUP : columns carried by the bus per output group
//   state_t         : collector FSM states
//   cnt_width()     : tile counter width (never below 1 bit)
// Optional feature macro used by files importing this package:
//   PSUM_COLLECT_RELU_EN
// ----------------------------------------------------------------------------
package psum_collect_pkg;

  localparam int COLS            = 8;
  localparam int SUM_WIDTH       = 32;
  localparam int BUS_WIDTH       = COLS * SUM_WIDTH / 2;
  localparam int ROW_WIDTH       = COLS * SUM_WIDTH;
  localparam int LANES_PER_GROUP = 4;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_GRAB_HI = 1'b1
  } state_t;

  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/psum_relu_lane.sv
// ----------------------------------------------------------------------------
// psum_relu_lane
// Single-lane signed ReLU clamp: a negative lane (sign bit set) becomes 0,
// anything else passes through unchanged. Purely combinational.
// Only compiled when PSUM_COLLECT_RELU_EN is defined.
// Ports:
//   i_lane [W-1:0] : raw partial sum
//   o_lane [W-1:0] : clamped partial sum
// ----------------------------------------------------------------------------
`ifdef PSUM_COLLECT_RELU_EN
module psum_relu_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_lane,
  output logic [W-1:0] o_lane
);

  assign o_lane = i_lane[W-1] ? '0 : i_lane;

endmodule
`endif

// File: rtl/psum_out_collector.sv
// ----------------------------------------------------------------------------
// psum_out_collector
// Reads the systolic array's 128-bit multiplexed partial-sum bus. On a capture
// request it freezes the array for one cycle (array_hold), grabs columns 0-3
// at the ack edge, switches output_group_sel to grab columns 4-7 on the next
// edge and presents the assembled 256-bit row on a valid/ready port. Results
// are counted per tile; res_last marks the final row of a tile and tile_done
// pulses one cycle after that row is delivered.
//
// Handshake: res_valid rises only with a full row in res_data; the row and
// res_last are held stable until a cycle where res_valid && res_ready, which
// is the single transfer event. capture_req is held by the requester until a
// cycle with capture_ack high; that cycle is the acceptance.
//
// Optional feature: PSUM_COLLECT_RELU_EN clamps negative lanes to 0 on the
// way into res_data (both halves, no extra latency).
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   capture_req        : row result present on the array output
//   capture_ack        : request accepted this cycle (low half captured)
//   array_hold         : freeze the array for the current cycle
//   output_group_sel   : 0 = columns 0-3, 1 = columns 4-7
//   psum_out_bus       : array multiplexed output bus
//   clear              : synchronous tile-counter clear
//   res_valid/ready    : result handshake
//   res_data           : row result, column c at [c*SUM_WIDTH +: SUM_WIDTH]
//   res_last           : current result is the last of its tile
//   tile_done          : pulse after the last result of a tile is delivered
//   o_dbg_state        : current FSM state
//   o_dbg_cnt          : current tile counter value
// ----------------------------------------------------------------------------
module psum_out_collector
  import psum_collect_pkg::*;
#(
  parameter int TILE_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              capture_req,
  output logic                              capture_ack,
  output logic                              array_hold,
  output logic                              output_group_sel,
  input  logic [BUS_WIDTH-1:0]              psum_out_bus,
  input  logic                              clear,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ROW_WIDTH-1:0]              res_data,
  output logic                              res_last,
  output logic                              tile_done,
  output state_t                            o_dbg_state,
  output logic [cnt_width(TILE_DEPTH)-1:0]  o_dbg_cnt
);

  localparam int              CNT_W    = cnt_width(TILE_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_DEPTH - 1);

  state_t                 r_state;
  logic [BUS_WIDTH-1:0]   r_lo;
  logic [ROW_WIDTH-1:0]   r_res_data;
  logic                   r_res_valid;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_tile_done;

  logic                   w_can_accept;
  logic                   w_ack;
  logic                   w_hs;
  logic                   w_at_last;
  logic [ROW_WIDTH-1:0]   w_row_raw;
  logic [ROW_WIDTH-1:0]   w_row;

  // A new capture may start in the same cycle the full register drains.
  assign w_can_accept = (r_state == S_IDLE) && (!r_res_valid || res_ready);
  // rst_n gating keeps the combinational outputs quiet while reset is held,
  // before the flops have been cleared by the first reset edge.
  assign w_ack        = rst_n && capture_req && w_can_accept;
  assign w_hs         = r_res_valid && res_ready;
  assign w_at_last    = (r_cnt == LAST_CNT);

  // High half comes straight off the bus in S_GRAB_HI; the array was frozen
  // across the ack edge so it is coherent with the captured low half.
  assign w_row_raw = {psum_out_bus, r_lo};

`ifdef PSUM_COLLECT_RELU_EN
  for (genvar c = 0; c < 2 * LANES_PER_GROUP; c++) begin : g_relu
    psum_relu_lane #(.W(SUM_WIDTH)) u_lane (
      .i_lane (w_row_raw[c*SUM_WIDTH +: SUM_WIDTH]),
      .o_lane (w_row[c*SUM_WIDTH +: SUM_WIDTH])
    );
  end
`else
  assign w_row = w_row_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_hs) begin
        r_res_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_ack) begin
            r_lo    <= psum_out_bus;
            r_state <= S_GRAB_HI;
          end
        end
        S_GRAB_HI: begin
          // The slot is always free here: acceptance required it to be
          // empty or draining at the ack edge.
          r_res_data  <= w_row;
          r_res_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tile counter: clear wins over a simultaneous increment and also
  // suppresses the tile_done pulse of that handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_tile_done <= w_hs && w_at_last && !clear;
      if (clear) begin
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign capture_ack      = w_ack;
  assign array_hold       = w_ack;
  assign output_group_sel = (r_state == S_GRAB_HI);
  assign res_valid        = r_res_valid;
  assign res_data         = r_res_data;
  assign res_last         = rst_n && r_res_valid && w_at_last;
  assign tile_done        = r_tile_done;
  assign o_dbg_state      = r_state;
  assign o_dbg_cnt        = r_cnt;

endmodule
